fft_engine_stream: RTL

Parametrised in-place radix-2 decimation-in-time FFT engine with a streaming load/unload interface. It accepts N = 2^LOG2_N complex samples over a valid/ready handshake, runs LOG2_N butterfly stages on an internal dual-entry RAM, and streams the N bins out in natural order. It is the next-generation FFT processor core, generalised in size and width. It adds back-pressure, per-stage scaling and a start/busy/done handshake. Twiddles come from the external twiddle ROM through a combinational address/data port.

---
 rtl/fft_engine_stream.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_engine_stream.sv
// Radix-2 DIT in-place FFT engine: streams N samples in, runs LOG2_N butterfly stages, streams N bins out.
// Latency: N accepted samples, then N*LOG2_N compute cycles (2 per butterfly), then bins from the next cycle on.
// Backpressure: in_ready only in LOAD (gaps stall the load); out_valid holds data/index stable until out_ready.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start / busy / done        frame request (IDLE only), frame active, one-cycle end-of-frame pulse
//   in_valid/in_ready/in_*     sample input handshake, samples in arrival order
//   out_valid/out_ready/out_*  bin output handshake, bins in natural order with out_index
//   tw_addr / tw_real/tw_imag  combinational twiddle ROM port: cos(2*pi*k/N), -sin(2*pi*k/N)
// Optional: define FFT_INVERSE_EN to add the 'inverse' input (conjugated twiddles, IDFT/N).
module fft_engine_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 5,
  parameter int TW_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef FFT_INVERSE_EN
  input  logic                  inverse,
`endif
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [LOG2_N-1:0]     out_index,
  output logic [LOG2_N-2:0]     tw_addr,
  input  logic [TW_WIDTH-1:0]   tw_real,
  input  logic [TW_WIDTH-1:0]   tw_imag
);

  localparam int N    = 1 << LOG2_N;
  localparam int HALF = N / 2;
  localparam int DW   = DATA_WIDTH;
  localparam int SW   = $clog2(LOG2_N);
  // Product width: DW x (TW+1) products plus one bit for the sum/difference.
  localparam int PW   = DW + TW_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_t;

  // Control and output registers
  state_t                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [DW-1:0]            out_re_q;
  logic [DW-1:0]            out_im_q;
  logic [LOG2_N-1:0]        out_idx_q;
  logic [LOG2_N-2:0]        tw_addr_q;
  logic [LOG2_N-1:0]        load_cnt_q;
  logic [SW-1:0]            stage_q;
  logic [LOG2_N-2:0]        bfly_q;
  logic                     phase_q;   // 0 = read cycle, 1 = write cycle
`ifdef FFT_INVERSE_EN
  logic                     inv_q;
`endif

  // Butterfly operands captured in the read cycle
  logic signed [DW-1:0]       a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [TW_WIDTH-1:0] w_re_q;
  logic signed [TW_WIDTH:0]   w_im_q;  // one extra bit so negating -2^(TW-1) cannot wrap
  logic                       k_zero_q;

  // Sample/bin storage: {real, imag} per entry, not cleared by reset
  logic [2*DW-1:0] ram_q [N];

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
    logic [LOG2_N-1:0] r;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = v[LOG2_N-1-i];
    end
    return r;
  endfunction

  // A = g*2*span + j with g = b >> s, j = b mod span
  function automatic logic [LOG2_N-1:0] addr_a_f(input int s, input int b);
    int mask;
    mask = (1 << s) - 1;
    return LOG2_N'(((b >> s) << (s + 1)) | (b & mask));
  endfunction

  // k = j << (LOG2_N-1-s)
  function automatic logic [LOG2_N-2:0] twk_f(input int s, input int b);
    int mask;
    mask = (1 << s) - 1;
    return (LOG2_N-1)'((b & mask) << (LOG2_N - 1 - s));
  endfunction

  logic [LOG2_N-1:0] addr_a, addr_b;
  logic [LOG2_N-1:0] out_idx_nxt;

  always_comb begin
    addr_a      = addr_a_f(int'(stage_q), int'(bfly_q));
    addr_b      = addr_a | (LOG2_N'(1) << stage_q);
    out_idx_nxt = out_idx_q + LOG2_N'(1);
  end

  // ---------------------------------------------------------------------------
  // Twiddle conditioning (conjugate for the inverse transform)
  // ---------------------------------------------------------------------------
  logic signed [TW_WIDTH:0] tw_im_ext, w_im_d;

  always_comb begin
    tw_im_ext = (TW_WIDTH+1)'($signed(tw_imag));
    w_im_d    = tw_im_ext;
`ifdef FFT_INVERSE_EN
    if (inv_q) begin
      w_im_d = -tw_im_ext;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Butterfly datapath (evaluated in the write cycle from captured operands)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0]   br_x, bi_x, wr_x, wi_x, prod_re, prod_im;
  logic signed [DW:0]     t_re, t_im;
  logic signed [DW+1:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0]   a_new_re, a_new_im, b_new_re, b_new_im;

  always_comb begin
    br_x    = PW'(b_re_q);
    bi_x    = PW'(b_im_q);
    wr_x    = PW'(w_re_q);
    wi_x    = PW'(w_im_q);
    prod_re = br_x * wr_x - bi_x * wi_x;
    prod_im = br_x * wi_x + bi_x * wr_x;
    // k = 0 means W = 1, which Q1.(TW-1) cannot hold exactly, so pass B through.
    if (k_zero_q) begin
      t_re = (DW+1)'(b_re_q);
      t_im = (DW+1)'(b_im_q);
    end else begin
      t_re = (DW+1)'(prod_re >>> (TW_WIDTH - 1));
      t_im = (DW+1)'(prod_im >>> (TW_WIDTH - 1));
    end
    sum_re   = (DW+2)'(a_re_q) + (DW+2)'(t_re);
    sum_im   = (DW+2)'(a_im_q) + (DW+2)'(t_im);
    dif_re   = (DW+2)'(a_re_q) - (DW+2)'(t_re);
    dif_im   = (DW+2)'(a_im_q) - (DW+2)'(t_im);
    // Halving every stage gives the overall 1/N scaling and keeps the result in range.
    a_new_re = DW'(sum_re >>> 1);
    a_new_im = DW'(sum_im >>> 1);
    b_new_re = DW'(dif_re >>> 1);
    b_new_im = DW'(dif_im >>> 1);
  end

  // ---------------------------------------------------------------------------
  // RAM writes: bit-reversed load, then in-place butterfly results
  // ---------------------------------------------------------------------------
  logic load_we, bf_we;

  always_comb begin
    load_we = (state_q == ST_LOAD) && in_valid && in_ready_q;
    bf_we   = (state_q == ST_COMPUTE) && phase_q;
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      ram_q[bitrev(load_cnt_q)] <= {in_real, in_imag};
    end
    if (bf_we) begin
      ram_q[addr_a] <= {a_new_re, a_new_im};
      ram_q[addr_b] <= {b_new_re, b_new_im};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      tw_addr_q   <= '0;
      load_cnt_q  <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      phase_q     <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      w_re_q      <= '0;
      w_im_q      <= '0;
      k_zero_q    <= 1'b0;
`ifdef FFT_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            load_cnt_q <= '0;
`ifdef FFT_INVERSE_EN
            inv_q      <= inverse;
`endif
          end
        end

        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (load_cnt_q == LOG2_N'(N - 1)) begin
              state_q    <= ST_COMPUTE;
              in_ready_q <= 1'b0;
              stage_q    <= '0;
              bfly_q     <= '0;
              phase_q    <= 1'b0;
              tw_addr_q  <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + LOG2_N'(1);
            end
          end
        end

        ST_COMPUTE: begin
          if (!phase_q) begin
            // Read cycle: tw_addr already holds k for this butterfly.
            {a_re_q, a_im_q} <= ram_q[addr_a];
            {b_re_q, b_im_q} <= ram_q[addr_b];
            w_re_q           <= tw_real;
            w_im_q           <= w_im_d;
            k_zero_q         <= (tw_addr_q == '0);
            phase_q          <= 1'b1;
          end else begin
            // Write cycle: RAM block stores results; step to the next butterfly
            // and pre-load its twiddle index so it is valid in its read cycle.
            phase_q <= 1'b0;
            if (bfly_q == (LOG2_N-1)'(HALF - 1)) begin
              bfly_q <= '0;
              if (stage_q == SW'(LOG2_N - 1)) begin
                // Bin 0 is never touched by the final butterfly, so it can be read now.
                state_q     <= ST_UNLOAD;
                out_valid_q <= 1'b1;
                out_idx_q   <= '0;
                out_re_q    <= ram_q[0][2*DW-1:DW];
                out_im_q    <= ram_q[0][DW-1:0];
              end else begin
                stage_q   <= stage_q + SW'(1);
                tw_addr_q <= '0;
              end
            end else begin
              bfly_q    <= bfly_q + (LOG2_N-1)'(1);
              tw_addr_q <= twk_f(int'(stage_q), int'(bfly_q) + 1);
            end
          end
        end

        ST_UNLOAD: begin
          if (out_valid_q && out_ready) begin
            if (out_idx_q == LOG2_N'(N - 1)) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_idx_q <= out_idx_nxt;
              out_re_q  <= ram_q[out_idx_nxt][2*DW-1:DW];
              out_im_q  <= ram_q[out_idx_nxt][DW-1:0];
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;
  assign out_index = out_idx_q;
  assign tw_addr   = tw_addr_q;

endmodule
